fetch_unit: RTL

- Instruction-fetch consumer at the other end of the PC_MOD interface.
- Each cycle PC_MOD presents a PC. This block reads the instruction at that PC from instruction memory over a req/ack handshake and buffers it for decode.
- It drives PC_MOD's control inputs back: stall, shouldJump and BranchAmmount. The PC therefore advances exactly once per fetched instruction, and relative branches are redirected at fetch time.
- Only one memory request is outstanding at a time, so no wrong-path fetch ever occurs.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants, state encoding and helpers.
// Instruction fields and branch offset sign extension live here.
package fetch_pkg;

    localparam logic [3:0] OPC_BRANCH = 4'hC;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OFF_MSB = 11;
    localparam int OFF_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ADV
    } state_e;

    function automatic logic [15:0] sext12(input logic [11:0] v);
        return {{4{v[11]}}, v};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Count-based instruction buffer between fetch and decode.
// A pop frees a slot first, so push+pop while full is accepted.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] data_o,
    output logic [AW:0]  count_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;
    logic          do_pop;
    logic          do_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

    a_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        (pop_i && empty_o && !push_i && !flush_i) |=> empty_o);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding memory read, PC advanced once per
// fetched word, relative branches redirected at fetch time.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] PC,
    output logic        stall,
    output logic        shouldJump,
    output logic [15:0] BranchAmmount,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    input  logic        instr_ready,
    input  logic        flush
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q;
    logic          stall_q;
    logic          req_q;
    logic [15:0]   cap_q;
    logic          push;
    logic          pop;
    logic          room;
    logic          full;
    logic          empty;
    logic          is_br;
    logic [CW-1:0] count;

    assign push = (state_q == WAIT) & mem_ack;
    assign pop  = instr_valid & instr_ready;
    // No push happens in IDLE/ADV, so room only depends on pop/flush.
    assign room = ~full | pop | flush;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (mem_rdata),
        .pop_i   (instr_ready),
        .flush_i (flush),
        .data_o  (instr),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stall_q <= 1'b1;
            req_q   <= 1'b0;
            cap_q   <= '0;
        end else begin
            stall_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (room) begin
                        state_q <= WAIT;
                        req_q   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        cap_q   <= mem_rdata;
                        state_q <= ADV;
                        req_q   <= 1'b0;
                        stall_q <= 1'b0;
                    end
                end
                ADV: begin
                    state_q <= room ? WAIT : IDLE;
                    req_q   <= room;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign is_br         = (cap_q[OPC_MSB:OPC_LSB] == OPC_BRANCH);
    assign stall         = stall_q;
    assign shouldJump    = (state_q == ADV) & is_br;
    assign BranchAmmount = shouldJump ? sext12(cap_q[OFF_MSB:OFF_LSB]) : '0;
    assign mem_req       = req_q;
    assign mem_addr      = PC;
    assign instr_valid   = ~empty;

    a_ack_ignored: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != WAIT) |-> !push);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(FIFO_DEPTH));

endmodule
